// File: rtl/lanes_deserializer_pkg.sv
// Shared constants for the lane serializer/deserializer pair.
// Holds the gen_speed encodings, per-speed word widths and the sync header constants,
// plus small helpers for decoding the speed field and checking a sync header.
package lanes_deserializer_pkg;

    // Raw encoding 2'b11 is not a state of its own; it decodes to GEN4.
    typedef enum logic [1:0] {
        SpdGen4 = 2'b00,
        SpdGen3 = 2'b01,
        SpdGen2 = 2'b10
    } gen_speed_e;

    localparam int unsigned WORD_W_GEN4 = 8;
    localparam int unsigned WORD_W_GEN3 = 132;
    localparam int unsigned WORD_W_GEN2 = 66;

    localparam logic [1:0] SYNC2_HDR_A = 2'b01;
    localparam logic [1:0] SYNC2_HDR_B = 2'b10;
    localparam logic [3:0] SYNC3_HDR_A = 4'b0101;
    localparam logic [3:0] SYNC3_HDR_B = 4'b1010;

    function automatic gen_speed_e decode_speed(input logic [1:0] raw);
        case (raw)
            2'b01:   return SpdGen3;
            2'b10:   return SpdGen2;
            default: return SpdGen4;
        endcase
    endfunction

    // hdr holds the word's low four bits; GEN2 only looks at [1:0]. GEN4 has no header.
    function automatic logic sync_hdr_ok(input gen_speed_e spd, input logic [3:0] hdr);
        case (spd)
            SpdGen2: return (hdr[1:0] == SYNC2_HDR_A) || (hdr[1:0] == SYNC2_HDR_B);
            SpdGen3: return (hdr == SYNC3_HDR_A) || (hdr == SYNC3_HDR_B);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_deser_shifter.sv
// Per-lane word accumulator.
// Places each received bit at its final position in the word (MSB-first for GEN4,
// LSB-first for GEN3/GEN2) so the assembled word needs no realignment at the boundary.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   enable    deserializing; low clears the partial word
//   done      this cycle samples the last bit of the word; accumulator restarts
//   spd       latched speed
//   count     index of the bit being sampled this cycle
//   ser       serial input bit
//   word      assembled word including this cycle's bit (combinational)
module lane_deser_shifter
    import lanes_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH         = 132,
    parameter int unsigned COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     done,
    input  gen_speed_e               spd,
    input  logic [COUNTER_WIDTH-1:0] count,
    input  logic                     ser,
    output logic [WIDTH-1:0]         word
);

    logic [WIDTH-1:0]         acc_q;
    logic [WIDTH-1:0]         acc_d;
    logic [COUNTER_WIDTH-1:0] idx;

    always_comb begin
        idx = count;
        if (spd == SpdGen4) begin
            idx = COUNTER_WIDTH'(WORD_W_GEN4 - 1) - count;
        end
        word      = acc_q;
        word[idx] = ser;
        // Upper bits stay zero because the accumulator restarts cleared every word.
        acc_d = (!enable || done) ? '0 : word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/lanes_deserializer.sv
// Two-lane receive deserializer.
// Collects lane 0/1 serial bits into parallel words sized by the latched speed
// (GEN4 8b MSB-first, GEN3 132b LSB-first, GEN2 66b LSB-first) and strobes both words out
// together, with a descrambler seed-reset pulse on every word boundary.
// Optional sync-header checker: define RX_SYNC_CHK_EN to enable; otherwise sync_err is 0.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   enable_deser          1 = deserialize, 0 = idle/cleared (speed latched while idle)
//   gen_speed             00 GEN4, 01 GEN3, 10 GEN2, 11 GEN4
//   lane_0/1_rx_ser       serial input bits, one per clk
//   lane_0/1_rx_parallel  assembled words, held between strobes
//   rx_word_valid         1-cycle strobe when both words update
//   descr_rst             1-cycle descrambler seed reset at the word boundary
//   enable_descr          enable_deser delayed one clk
//   sync_err              invalid sync header on either lane at the strobe
module lanes_deserializer
    import lanes_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_deser,
    input  logic [1:0]       gen_speed,
    input  logic             lane_0_rx_ser,
    input  logic             lane_1_rx_ser,
    output logic [WIDTH-1:0] lane_0_rx_parallel,
    output logic [WIDTH-1:0] lane_1_rx_parallel,
    output logic             rx_word_valid,
    output logic             descr_rst,
    output logic             enable_descr,
    output logic             sync_err
);

    localparam int unsigned COUNTER_WIDTH = $clog2(WIDTH);

    gen_speed_e               spd_q;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;
    logic [COUNTER_WIDTH-1:0] last_idx;
    logic                     done;
    logic [WIDTH-1:0]         word_0;
    logic [WIDTH-1:0]         word_1;

    always_comb begin
        case (spd_q)
            SpdGen3: last_idx = COUNTER_WIDTH'(WORD_W_GEN3 - 1);
            SpdGen2: last_idx = COUNTER_WIDTH'(WORD_W_GEN2 - 1);
            default: last_idx = COUNTER_WIDTH'(WORD_W_GEN4 - 1);
        endcase
    end

    // done marks the cycle whose bit completes the word; outputs load on that same edge,
    // so the strobe is visible in the following cycle.
    assign done = enable_deser && (count_q == last_idx);

    always_comb begin
        count_d = count_q + COUNTER_WIDTH'(1);
        if (!enable_deser || done) begin
            count_d = '0;
        end
    end

    lane_deser_shifter #(
        .WIDTH         (WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_shifter_0 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable_deser),
        .done   (done),
        .spd    (spd_q),
        .count  (count_q),
        .ser    (lane_0_rx_ser),
        .word   (word_0)
    );

    lane_deser_shifter #(
        .WIDTH         (WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_shifter_1 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable_deser),
        .done   (done),
        .spd    (spd_q),
        .count  (count_q),
        .ser    (lane_1_rx_ser),
        .word   (word_1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spd_q              <= SpdGen4;
            count_q            <= '0;
            lane_0_rx_parallel <= '0;
            lane_1_rx_parallel <= '0;
            rx_word_valid      <= 1'b0;
            descr_rst          <= 1'b0;
            enable_descr       <= 1'b0;
        end else begin
            // Speed is frozen for the whole enabled period.
            if (!enable_deser) begin
                spd_q <= decode_speed(gen_speed);
            end
            count_q       <= count_d;
            rx_word_valid <= done;
            descr_rst     <= done;
            enable_descr  <= enable_deser;
            if (!enable_deser) begin
                lane_0_rx_parallel <= '0;
                lane_1_rx_parallel <= '0;
            end else if (done) begin
                lane_0_rx_parallel <= word_0;
                lane_1_rx_parallel <= word_1;
            end
        end
    end

`ifdef RX_SYNC_CHK_EN
    logic sync_bad;

    assign sync_bad = !(sync_hdr_ok(spd_q, word_0[3:0]) && sync_hdr_ok(spd_q, word_1[3:0]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= done && sync_bad;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_lanes_deserializer.sv
module tb_lanes_deserializer;

    localparam int unsigned W = 132;
    typedef logic [W-1:0] word_t;

    typedef struct {
        int    cyc;
        word_t w0;
        word_t w1;
        logic  dr;
        logic  se;
    } strobe_t;

    logic       clk;
    logic       rst;
    logic       enable_deser;
    logic [1:0] gen_speed;
    logic       lane_0_rx_ser;
    logic       lane_1_rx_ser;
    word_t      lane_0_rx_parallel;
    word_t      lane_1_rx_parallel;
    logic       rx_word_valid;
    logic       descr_rst;
    logic       enable_descr;
    logic       sync_err;

    int total;
    int bad;
    int cyc;

    strobe_t q[$];
    word_t   exp0[$];
    word_t   exp1[$];
    int      exp_cyc[$];
    logic    exp_se[$];

    lanes_deserializer #(
        .WIDTH (W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_deser       (enable_deser),
        .gen_speed          (gen_speed),
        .lane_0_rx_ser      (lane_0_rx_ser),
        .lane_1_rx_ser      (lane_1_rx_ser),
        .lane_0_rx_parallel (lane_0_rx_parallel),
        .lane_1_rx_parallel (lane_1_rx_parallel),
        .rx_word_valid      (rx_word_valid),
        .descr_rst          (descr_rst),
        .enable_descr       (enable_descr),
        .sync_err           (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe with the cycle it appeared in.
    always @(negedge clk) begin
        if (rx_word_valid) begin
            q.push_back('{cyc: cyc, w0: lane_0_rx_parallel, w1: lane_1_rx_parallel,
                          dr: descr_rst, se: sync_err});
        end
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_sync(input int n, input word_t a, input word_t b);
        logic err;
        err = 1'b0;
`ifdef RX_SYNC_CHK_EN
        if (n == 66) begin
            err = !((a[1:0] == 2'b01 || a[1:0] == 2'b10) && (b[1:0] == 2'b01 || b[1:0] == 2'b10));
        end else if (n == 132) begin
            err = !((a[3:0] == 4'h5 || a[3:0] == 4'hA) && (b[3:0] == 4'h5 || b[3:0] == 4'hA));
        end
`else
        if (n < 0) err = a[0] ^ b[0];
`endif
        return err;
    endfunction

    function automatic word_t rand_word();
        return {4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive bits [first, first+n) of each word, one per clk, enable held high.
    task automatic stream(input int first, input int n, input word_t w0, input word_t w1,
                          input bit msb8, output int last);
        last = 0;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            enable_deser  = 1'b1;
            lane_0_rx_ser = msb8 ? w0[7 - i] : w0[i];
            lane_1_rx_ser = msb8 ? w1[7 - i] : w1[i];
            last = cyc;
        end
    endtask

    task automatic send_word(input word_t w0, input word_t w1, input int n, input bit msb8);
        int last;
        stream(0, n, w0, w1, msb8, last);
        exp0.push_back(w0);
        exp1.push_back(w1);
        exp_cyc.push_back(last + 1);
        exp_se.push_back(exp_sync(n, w0, w1));
    endtask

    task automatic stop_stream();
        @(negedge clk);
        enable_deser  = 1'b0;
        lane_0_rx_ser = 1'b0;
        lane_1_rx_ser = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_speed(input logic [1:0] raw);
        @(negedge clk);
        enable_deser = 1'b0;
        gen_speed    = raw;
        repeat (2) @(negedge clk);
        q.delete();
    endtask

    task automatic verify(input string tag);
        check({tag, " strobes"}, word_t'(q.size()), word_t'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < q.size(); i++) begin
            check($sformatf("%s[%0d] cycle", tag, i), word_t'(q[i].cyc), word_t'(exp_cyc[i]));
            check($sformatf("%s[%0d] lane0", tag, i), q[i].w0, exp0[i]);
            check($sformatf("%s[%0d] lane1", tag, i), q[i].w1, exp1[i]);
            check($sformatf("%s[%0d] descr_rst", tag, i), word_t'(q[i].dr), word_t'(1));
            check($sformatf("%s[%0d] sync_err", tag, i), word_t'(q[i].se), word_t'(exp_se[i]));
        end
        q.delete();
        exp0.delete();
        exp1.delete();
        exp_cyc.delete();
        exp_se.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, " lane0"}, lane_0_rx_parallel, '0);
        check({tag, " lane1"}, lane_1_rx_parallel, '0);
        check({tag, " valid"}, word_t'(rx_word_valid), '0);
        check({tag, " descr_rst"}, word_t'(descr_rst), '0);
        check({tag, " enable_descr"}, word_t'(enable_descr), '0);
        check({tag, " sync_err"}, word_t'(sync_err), '0);
    endtask

    initial begin
        int    last;
        word_t w;
        word_t v;

        total         = 0;
        bad           = 0;
        cyc           = 0;
        rst           = 1'b0;
        enable_deser  = 1'b0;
        gen_speed     = 2'b00;
        lane_0_rx_ser = 1'b0;
        lane_1_rx_ser = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_idle("idle after reset");
        check("idle strobes", word_t'(q.size()), '0);

        // GEN4: 1,0,1,1,0,0,1,0 -> 8'hB2, complement on lane 1
        set_speed(2'b00);
        send_word(word_t'(8'hB2), word_t'(8'h4D), 8, 1'b1);
        @(negedge clk);
        lane_0_rx_ser = 1'b0;
        lane_1_rx_ser = 1'b0;
        check("gen4 valid at strobe", word_t'(rx_word_valid), word_t'(1));
        check("gen4 descr_rst at strobe", word_t'(descr_rst), word_t'(1));
        @(negedge clk);
        check("gen4 valid after", word_t'(rx_word_valid), '0);
        check("gen4 descr_rst after", word_t'(descr_rst), '0);
        check("gen4 hold lane0", lane_0_rx_parallel, word_t'(8'hB2));
        check("gen4 hold lane1", lane_1_rx_parallel, word_t'(8'h4D));
        check("gen4 enable_descr", word_t'(enable_descr), word_t'(1));
        // Asynchronous reset mid-word
        #2 rst = 1'b0;
        #1 check_idle("async reset");
        verify("gen4");
        @(negedge clk);
        rst          = 1'b1;
        enable_deser = 1'b0;
        repeat (20) @(negedge clk);
        check("post-reset strobes", word_t'(q.size()), '0);
        check_idle("post-reset idle");

        // GEN2: three back-to-back words
        set_speed(2'b10);
        w = word_t'(66'h2_0123_4567_89AB_CDEF);
        send_word(w, w, 66, 1'b0);
        send_word(word_t'(66'h1_FEDC_BA98_7654_3211), word_t'(66'h3_0F0F_F0F0_5A5A_A5A6),
                  66, 1'b0);
        send_word(word_t'(66'h0_8000_0000_0000_0001), word_t'(66'h2_FFFF_FFFF_FFFF_FFFE),
                  66, 1'b0);
        stop_stream();
        verify("gen2");

        // GEN3: four random words back-to-back
        set_speed(2'b01);
        for (int i = 0; i < 4; i++) begin
            send_word(rand_word(), rand_word(), 132, 1'b0);
        end
        stop_stream();
        verify("gen3");

        // Abort after 40 GEN3 bits
        set_speed(2'b01);
        stream(0, 40, rand_word(), rand_word(), 1'b0, last);
        stop_stream();
        verify("abort");
        check("abort lane0 cleared", lane_0_rx_parallel, '0);

        // Speed change while enabled is ignored: still a 132-bit word
        set_speed(2'b01);
        w = rand_word();
        v = rand_word();
        stream(0, 10, w, v, 1'b0, last);
        gen_speed = 2'b10;
        stream(10, 122, w, v, 1'b0, last);
        exp0.push_back(w);
        exp1.push_back(v);
        exp_cyc.push_back(last + 1);
        exp_se.push_back(exp_sync(132, w, v));
        stop_stream();
        verify("speed ignored");

        // GEN2 latched while disabled takes effect on re-enable
        repeat (2) @(negedge clk);
        q.delete();
        send_word(word_t'(66'h1_2345_6789_ABCD_EF01), word_t'(66'h2_AAAA_5555_0000_FFFE),
                  66, 1'b0);
        stop_stream();
        verify("gen2 re-enable");

        // Sync headers: lane1 2'b11, then both 2'b01
        set_speed(2'b10);
        send_word(word_t'(66'h3_FFFF_0000_1234_5671), word_t'(66'h0_0000_FFFF_4321_8763),
                  66, 1'b0);
        send_word(word_t'(66'h0_1111_2222_3333_4445), word_t'(66'h2_9999_8888_7777_6665),
                  66, 1'b0);
        stop_stream();
        verify("sync");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
